// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// datapath mux selects and the bundled control word.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_HALT      = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    ALUB_REG    = 2'b00,
    ALUB_FOUR   = 2'b01,
    ALUB_IMM    = 2'b10,
    ALUB_IMM_SH = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    pc_src_e    pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational decode of (state, mem_ready) into the datapath control word.
// enable low forces the whole word to zero so reset silences the datapath.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_e state,
  input  logic   mem_ready,
  input  logic   enable,
  output ctrl_t  ctrl
);

  always_comb begin
    // NOTE: full default before the case keeps every field assigned on all paths, so no latch is inferred.
    ctrl = '0;
    if (enable) begin
      case (state)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = ALUB_FOUR;
          ctrl.alu_op    = ALU_ADD;
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
          ctrl.pc_src    = PC_ALU;
        end
        S_DECODE: begin
          ctrl.alu_src_b = ALUB_IMM_SH;
          ctrl.alu_op    = ALU_ADD;
        end
        S_MEM_ADDR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = ALUB_IMM;
        end
        S_MEM_RD: begin
          ctrl.mem_read = 1'b1;
          ctrl.i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_MEM_WR: begin
          ctrl.mem_write  = 1'b1;
          ctrl.i_or_d     = 1'b1;
          ctrl.instr_done = mem_ready;
        end
        S_R_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = ALUB_REG;
          ctrl.alu_op    = ALU_FUNCT;
        end
        S_R_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_BRANCH: begin
          // The zero qualification of the PC load lives in the datapath.
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_src_b     = ALUB_REG;
          ctrl.alu_op        = ALU_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_src        = PC_ALUOUT;
          ctrl.instr_done    = 1'b1;
        end
        S_JUMP: begin
          ctrl.pc_write   = 1'b1;
          ctrl.pc_src     = PC_JUMP;
          ctrl.instr_done = 1'b1;
        end
        S_ADDI_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = ALUB_IMM;
        end
        S_ADDI_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register, next-state logic, retired
// instruction counter and sticky halt flag around the output decoder.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W  = 6,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             instr_done,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  state_e             state_q, state_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   instr_count_q, instr_count_d;
  ctrl_t              ctrl;

  // zero is consumed by the datapath's branch qualification, not here.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_FETCH;
      halted_q      <= 1'b0;
      instr_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      halted_q      <= halted_d;
      instr_count_q <= instr_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if      (opcode == OP_W'(OP_RTYPE))                              state_d = S_R_EXEC;
        else if (opcode == OP_W'(OP_LW) || opcode == OP_W'(OP_SW))       state_d = S_MEM_ADDR;
        else if (opcode == OP_W'(OP_BEQ))                                state_d = S_BRANCH;
        else if (opcode == OP_W'(OP_J))                                  state_d = S_JUMP;
        else if (opcode == OP_W'(OP_ADDI))                               state_d = S_ADDI_EXEC;
        else                                                             state_d = S_HALT;
      end
      S_MEM_ADDR:  state_d = (opcode == OP_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:    state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WR:    state_d = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_HALT;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .enable    (rst),
    .ctrl      (ctrl)
  );

  // Set on the edge that enters HALT so the flag is visible in its first cycle.
  assign halted_d      = halted_q | (state_d == S_HALT);
  assign instr_count_d = instr_count_q + CNT_W'(ctrl.instr_done);

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_src        = ctrl.pc_src;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign instr_done    = ctrl.instr_done;
  assign halted        = halted_q;
  assign instr_count   = instr_count_q;
  assign state         = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multicycle MIPS controller: walks each instruction
// class cycle by cycle against hand-computed state and control values.
module tb_mips_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, halted;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic [31:0] instr_count;
  logic [3:0]  state;
  logic [17:0] ctrl_vec;

  int errors = 0;
  int checks = 0;

  mips_multicycle_ctrl #(.OP_W(6), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .instr_done(instr_done), .halted(halted),
    .instr_count(instr_count), .state(state)
  );

  assign ctrl_vec = {pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
                     ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                     alu_src_b, alu_op, instr_done, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (ctrl_vec !== 18'd0) begin errors++; $display("FAIL reset_outputs got %b want 0", ctrl_vec); end
    checks++;
    if (state !== 4'd0 || instr_count !== 32'd0) begin
      errors++; $display("FAIL reset_state got st=%0d cnt=%0d want st=0 cnt=0", state, instr_count);
    end
    mem_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rtype();
    logic [3:0] exp_st [4];
    int done_n = 0;
    exp_st = '{4'd0, 4'd1, 4'd6, 4'd7};
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; opcode = 6'h00; #1;
      checks++;
      if (state !== exp_st[i]) begin errors++; $display("FAIL rtype_state[%0d] got %0d want %0d", i, state, exp_st[i]); end
      if (instr_done) done_n++;
      if (i == 0) begin
        checks++;
        if ({ir_write, pc_write, pc_src, mem_read, alu_src_b} !== 7'b1_1_00_1_01) begin
          errors++; $display("FAIL rtype_fetch got %b want 1100101", {ir_write, pc_write, pc_src, mem_read, alu_src_b});
        end
      end
      if (i == 2) begin
        checks++;
        if ({alu_src_a, alu_src_b, alu_op} !== 5'b1_00_10) begin
          errors++; $display("FAIL rtype_exec got %b want 10010", {alu_src_a, alu_src_b, alu_op});
        end
      end
      if (i == 3) begin
        checks++;
        if ({reg_write, reg_dst, mem_to_reg} !== 3'b110) begin
          errors++; $display("FAIL rtype_wb got %b want 110", {reg_write, reg_dst, mem_to_reg});
        end
      end
      @(negedge clk);
    end
    checks++;
    if (done_n !== 1 || instr_count !== 32'd1 || state !== 4'd0) begin
      errors++; $display("FAIL rtype_retire got done=%0d cnt=%0d st=%0d want 1 1 0", done_n, instr_count, state);
    end
  endtask

  task automatic test_lw_waits();
    logic [3:0] exp_st [8];
    logic       mr [8];
    int ir_n = 0;
    exp_st = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4};
    mr     = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr[i]; opcode = 6'h23; #1;
      checks++;
      if (state !== exp_st[i]) begin errors++; $display("FAIL lw_state[%0d] got %0d want %0d", i, state, exp_st[i]); end
      if (ir_write) ir_n++;
      if (i == 0) begin
        checks++;
        if ({mem_read, ir_write, pc_write} !== 3'b100) begin
          errors++; $display("FAIL lw_fetch_wait got %b want 100", {mem_read, ir_write, pc_write});
        end
      end
      if (i == 5) begin
        checks++;
        if ({mem_read, i_or_d, instr_done} !== 3'b110) begin
          errors++; $display("FAIL lw_memrd_wait got %b want 110", {mem_read, i_or_d, instr_done});
        end
      end
      if (i == 7) begin
        checks++;
        if ({mem_to_reg, reg_write, reg_dst, instr_done} !== 4'b1101) begin
          errors++; $display("FAIL lw_wb got %b want 1101", {mem_to_reg, reg_write, reg_dst, instr_done});
        end
      end
      @(negedge clk);
    end
    checks++;
    if (ir_n !== 1 || instr_count !== 32'd2 || state !== 4'd0) begin
      errors++; $display("FAIL lw_retire got ir=%0d cnt=%0d st=%0d want 1 2 0", ir_n, instr_count, state);
    end
  endtask

  task automatic test_sw();
    logic [3:0] exp_st [4];
    logic any_rw = 1'b0;
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd5};
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; opcode = 6'h2B; #1;
      checks++;
      if (state !== exp_st[i]) begin errors++; $display("FAIL sw_state[%0d] got %0d want %0d", i, state, exp_st[i]); end
      any_rw |= reg_write;
      if (i == 2) begin
        checks++;
        if ({alu_src_a, alu_src_b, alu_op} !== 5'b1_10_00) begin
          errors++; $display("FAIL sw_addr got %b want 11000", {alu_src_a, alu_src_b, alu_op});
        end
      end
      if (i == 3) begin
        checks++;
        if ({mem_write, i_or_d, mem_read, instr_done} !== 4'b1101) begin
          errors++; $display("FAIL sw_memwr got %b want 1101", {mem_write, i_or_d, mem_read, instr_done});
        end
      end
      @(negedge clk);
    end
    checks++;
    if (any_rw !== 1'b0 || instr_count !== 32'd3 || state !== 4'd0) begin
      errors++; $display("FAIL sw_retire got rw=%b cnt=%0d st=%0d want 0 3 0", any_rw, instr_count, state);
    end
  endtask

  task automatic test_beq();
    logic [3:0] exp_st [3];
    exp_st = '{4'd0, 4'd1, 4'd8};
    for (int z = 1; z >= 0; z--) begin
      for (int i = 0; i < 3; i++) begin
        mem_ready = 1'b1; opcode = 6'h04; zero = z[0]; #1;
        checks++;
        if (state !== exp_st[i]) begin errors++; $display("FAIL beq_state[z%0d,%0d] got %0d want %0d", z, i, state, exp_st[i]); end
        if (i == 1) begin
          checks++;
          if ({alu_src_a, alu_src_b, alu_op} !== 5'b0_11_00) begin
            errors++; $display("FAIL beq_decode got %b want 01100", {alu_src_a, alu_src_b, alu_op});
          end
        end
        if (i == 2) begin
          checks++;
          if ({pc_write_cond, pc_src, alu_op, pc_write, instr_done} !== 7'b1_01_01_0_1) begin
            errors++; $display("FAIL beq_branch[z%0d] got %b want 1010101", z, {pc_write_cond, pc_src, alu_op, pc_write, instr_done});
          end
        end
        @(negedge clk);
      end
      checks++;
      if (instr_count !== 32'd5 - 32'(z) || state !== 4'd0) begin
        errors++; $display("FAIL beq_retire[z%0d] got cnt=%0d st=%0d want %0d 0", z, instr_count, state, 5 - z);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_jump_addi();
    logic [3:0] exp_j [3];
    logic [3:0] exp_a [4];
    logic       mr_a [4];
    exp_j = '{4'd0, 4'd1, 4'd9};
    exp_a = '{4'd0, 4'd1, 4'd10, 4'd11};
    mr_a  = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1; opcode = 6'h02; #1;
      checks++;
      if (state !== exp_j[i]) begin errors++; $display("FAIL j_state[%0d] got %0d want %0d", i, state, exp_j[i]); end
      if (i == 2) begin
        checks++;
        if ({pc_write, pc_src, pc_write_cond, instr_done} !== 5'b1_10_0_1) begin
          errors++; $display("FAIL j_jump got %b want 11001", {pc_write, pc_src, pc_write_cond, instr_done});
        end
      end
      @(negedge clk);
    end
    // mem_ready low outside memory states must not stall addi.
    for (int i = 0; i < 4; i++) begin
      mem_ready = mr_a[i]; opcode = 6'h08; #1;
      checks++;
      if (state !== exp_a[i]) begin errors++; $display("FAIL addi_state[%0d] got %0d want %0d", i, state, exp_a[i]); end
      if (i == 3) begin
        checks++;
        if ({reg_write, reg_dst, mem_to_reg, instr_done} !== 4'b1001) begin
          errors++; $display("FAIL addi_wb got %b want 1001", {reg_write, reg_dst, mem_to_reg, instr_done});
        end
      end
      @(negedge clk);
    end
    checks++;
    if (instr_count !== 32'd7 || state !== 4'd0) begin
      errors++; $display("FAIL j_addi_retire got cnt=%0d st=%0d want 7 0", instr_count, state);
    end
  endtask

  task automatic test_halt();
    logic [3:0] exp_st [5];
    logic       exp_h  [5];
    exp_st = '{4'd0, 4'd1, 4'd12, 4'd12, 4'd12};
    exp_h  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1; opcode = 6'h3F; #1;
      checks++;
      if (state !== exp_st[i] || halted !== exp_h[i]) begin
        errors++; $display("FAIL halt_state[%0d] got st=%0d h=%b want st=%0d h=%b", i, state, halted, exp_st[i], exp_h[i]);
      end
      if (i >= 2) begin
        checks++;
        if (ctrl_vec !== 18'd1) begin errors++; $display("FAIL halt_enables[%0d] got %b want 000000000000000001", i, ctrl_vec); end
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (instr_count !== 32'd7) begin errors++; $display("FAIL halt_count_frozen got %0d want 7", instr_count); end
    rst = 1'b0; #1;
    checks++;
    if (state !== 4'd0 || halted !== 1'b0 || instr_count !== 32'd0 || ctrl_vec !== 18'd0) begin
      errors++; $display("FAIL halt_reset got st=%0d h=%b cnt=%0d ctrl=%b want 0 0 0 0", state, halted, instr_count, ctrl_vec);
    end
    mem_ready = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    logic [3:0] exp_st [4];
    logic       mr [4];
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd3};
    mr     = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      mem_ready = mr[i]; opcode = 6'h23; #1;
      checks++;
      if (state !== exp_st[i]) begin errors++; $display("FAIL rstmid_state[%0d] got %0d want %0d", i, state, exp_st[i]); end
      if (i < 3) @(negedge clk);
    end
    #2 rst = 1'b0; #1;
    checks++;
    if (ctrl_vec !== 18'd0 || state !== 4'd0) begin
      errors++; $display("FAIL rstmid_async got ctrl=%b st=%0d want 0 0", ctrl_vec, state);
    end
    #2 rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({state, mem_read, i_or_d, alu_src_b, ir_write} !== {4'd0, 1'b1, 1'b0, 2'b01, 1'b0}) begin
      errors++; $display("FAIL rstmid_refetch got st=%0d rd=%b iod=%b srcb=%b ir=%b want 0 1 0 01 0",
                        state, mem_read, i_or_d, alu_src_b, ir_write);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_waits();
    test_sw();
    test_beq();
    test_jump_addi();
    test_halt();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
